// File: rtl/nolinear_seq.sv
// Command sequencer for the nolinear datapath: it latches one request, steps the micro-op rounds
// for softmax, gelu/silu or root, waits out the datapath drain and returns the result.
module nolinear_seq #(
    parameter int FIX_POINT_WIDTH = 16,
    parameter int DATA_NUM        = 4,
    parameter int Bf              = 8,
    parameter int R1_CYCLES       = 50,
    parameter int R2_CYCLES       = 1,
    parameter int ROOT_CYCLES     = 50,
    parameter int DRAIN_CYCLES    = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [1:0]                          req_op,
    input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] req_data,
    output logic [1:0]                          nl_mode,
    output logic [DATA_NUM*FIX_POINT_WIDTH-1:0] nl_in,
    output logic [2:0]                          nl_s_in,
    output logic                                nl_s_mux,
    output logic [2:0]                          nl_s_mult,
    output logic                                nl_s_add,
    output logic                                nl_en_mult,
    output logic                                nl_en_add,
    output logic                                nl_valid,
    input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] nl_out,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [DATA_NUM*FIX_POINT_WIDTH-1:0] rsp_data,
    output logic                                rsp_err
);

    localparam int DW = DATA_NUM * FIX_POINT_WIDTH;

    // DRAIN always lasts at least one cycle: nl_out is sampled on the edge that leaves it.
    localparam int DRAIN_HOLD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES : 1;
    localparam int MAX_A      = (R1_CYCLES > ROOT_CYCLES) ? R1_CYCLES : ROOT_CYCLES;
    localparam int MAX_B      = (R2_CYCLES > DRAIN_HOLD) ? R2_CYCLES : DRAIN_HOLD;
    localparam int MAX_CYC    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] R1_LOAD    = CNT_W'(R1_CYCLES - 1);
    localparam logic [CNT_W-1:0] R2_LOAD    = CNT_W'(R2_CYCLES - 1);
    localparam logic [CNT_W-1:0] ROOT_LOAD  = CNT_W'(ROOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_HOLD - 1);

    localparam logic [1:0] OP_SOFTMAX = 2'b00;
    localparam logic [1:0] OP_GELU    = 2'b01;
    localparam logic [1:0] OP_ROOT    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    generate
        if ((R1_CYCLES < 1) || (R2_CYCLES < 1) || (ROOT_CYCLES < 1) || (DRAIN_CYCLES < 0) ||
            (Bf >= FIX_POINT_WIDTH)) begin : g_bad_cfg
            $error("nolinear_seq: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        R1,
        R2,
        DRAIN,
        RESP
    } state_t;

    typedef struct packed {
        logic [2:0] s_in;
        logic       s_mux;
        logic [2:0] s_mult;
        logic       s_add;
        logic       en_mult;
        logic       en_add;
        logic       valid;
    } ctrl_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [1:0]        op_q, op_n;
    ctrl_t             ctrl_q, ctrl_n;
    logic              accept;
    logic              drain_done;

    assign accept     = req_valid && req_ready;
    assign op_n       = accept ? req_op : op_q;
    assign drain_done = (state == DRAIN) && (cnt == '0);

    // Next-state and round counter; the counter is reloaded on every round entry.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_op == OP_ILLEGAL) begin
                        state_n = RESP;
                    end else begin
                        state_n = R1;
                        cnt_n   = (req_op == OP_ROOT) ? ROOT_LOAD : R1_LOAD;
                    end
                end
            end
            R1: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (op_q == OP_ROOT) begin
                    state_n = DRAIN;
                    cnt_n   = DRAIN_LOAD;
                end else begin
                    state_n = R2;
                    cnt_n   = R2_LOAD;
                end
            end
            R2: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = DRAIN;
                    cnt_n   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Micro-op decode for the state being entered, so controls come out of flops.
    always_comb begin
        ctrl_n = '0;
        if (state_n == R1) begin
            ctrl_n.en_mult = 1'b1;
            case (op_n)
                OP_SOFTMAX: begin
                    ctrl_n.s_in   = 3'd0;
                    ctrl_n.s_mux  = 1'b1;
                    ctrl_n.s_mult = 3'd2;
                    ctrl_n.s_add  = 1'b1;
                end
                OP_GELU: begin
                    ctrl_n.s_in   = 3'd2;
                    ctrl_n.s_mux  = 1'b1;
                    ctrl_n.s_mult = 3'd4;
                end
                OP_ROOT: begin
                    ctrl_n.s_in   = 3'd2;
                    ctrl_n.s_mult = 3'd1;
                end
                default: ctrl_n = '0;
            endcase
        end else if (state_n == R2) begin
            ctrl_n.s_add  = 1'b1;
            ctrl_n.en_add = 1'b1;
            ctrl_n.valid  = 1'b1;
            if (op_n == OP_SOFTMAX) begin
                ctrl_n.s_in    = 3'd1;
                ctrl_n.en_mult = 1'b1;
            end else begin
                ctrl_n.s_in = 3'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            ctrl_q    <= '0;
            nl_mode   <= '0;
            nl_in     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            op_q      <= op_n;
            ctrl_q    <= ctrl_n;
            req_ready <= (state_n == IDLE);
            rsp_valid <= (state_n == RESP);
            if (accept) begin
                nl_mode <= req_op;
                nl_in   <= req_data;
                rsp_err <= (req_op == OP_ILLEGAL);
                if (req_op == OP_ILLEGAL) begin
                    rsp_data <= '0;
                end
            end else if (drain_done) begin
                rsp_data <= nl_out;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_err <= 1'b0;
            end
        end
    end

    assign nl_s_in    = ctrl_q.s_in;
    assign nl_s_mux   = ctrl_q.s_mux;
    assign nl_s_mult  = ctrl_q.s_mult;
    assign nl_s_add   = ctrl_q.s_add;
    assign nl_en_mult = ctrl_q.en_mult;
    assign nl_en_add  = ctrl_q.en_add;
    assign nl_valid   = ctrl_q.valid;

endmodule

// File: tb/tb_nolinear_seq.sv
// Scoreboard bench for nolinear_seq: a time-varying nl_out pattern pins down the drain sampling
// point, and a small round model predicts every micro-op control cycle by cycle.
module tb_nolinear_seq;

    localparam int DW         = 64;
    localparam int R1C        = 50;
    localparam int R2C        = 1;
    localparam int ROOTC      = 50;
    localparam int DRAINC     = 2;
    localparam int DRAIN_HOLD = (DRAINC > 0) ? DRAINC : 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [DW-1:0] req_data;
    logic [1:0]    nl_mode;
    logic [DW-1:0] nl_in;
    logic [2:0]    nl_s_in;
    logic          nl_s_mux;
    logic [2:0]    nl_s_mult;
    logic          nl_s_add;
    logic          nl_en_mult;
    logic          nl_en_add;
    logic          nl_valid;
    logic [DW-1:0] nl_out;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [10:0]   ctrl_obs;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tick     = 0;

    nolinear_seq #(
        .FIX_POINT_WIDTH(16), .DATA_NUM(4), .Bf(8), .R1_CYCLES(R1C), .R2_CYCLES(R2C),
        .ROOT_CYCLES(ROOTC), .DRAIN_CYCLES(DRAINC)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .nl_mode(nl_mode), .nl_in(nl_in), .nl_s_in(nl_s_in),
        .nl_s_mux(nl_s_mux), .nl_s_mult(nl_s_mult), .nl_s_add(nl_s_add),
        .nl_en_mult(nl_en_mult), .nl_en_add(nl_en_add), .nl_valid(nl_valid), .nl_out(nl_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    function automatic logic [DW-1:0] out_pattern(input int t);
        logic [15:0] v;
        v = 16'(t);
        return {v ^ 16'hA5A5, v, ~v, v + 16'h1234};
    endfunction

    assign nl_out   = out_pattern(tick);
    assign ctrl_obs = {nl_s_in, nl_s_mux, nl_s_mult, nl_s_add, nl_en_mult, nl_en_add, nl_valid};

    function automatic int exp_latency(input logic [1:0] op);
        case (op)
            2'b10:   return ROOTC + DRAIN_HOLD + 1;
            2'b11:   return 1;
            default: return R1C + R2C + DRAIN_HOLD + 1;
        endcase
    endfunction

    // Controls expected in cycle c after accept: {s_in, s_mux, s_mult, s_add, en_mult, en_add, valid}.
    function automatic logic [10:0] exp_ctrl(input logic [1:0] op, input int c);
        int r1len;
        if (op == 2'b11) return '0;
        r1len = (op == 2'b10) ? ROOTC : R1C;
        if (c >= 1 && c <= r1len) begin
            case (op)
                2'b00:   return {3'd0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
                2'b01:   return {3'd2, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0};
                default: return {3'd2, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0};
            endcase
        end
        if (op != 2'b10 && c > r1len && c <= r1len + R2C) begin
            if (op == 2'b00) return {3'd1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1};
            return {3'd3, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        end
        return '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [DW-1:0] data, input int hold,
                          input string name);
        exp_t          e;
        int            c;
        bit            got;
        logic [DW-1:0] held;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s accept_ready: got %b expected 1", name, req_ready);
        end
        e.data = (op == 2'b11) ? '0 : out_pattern(tick + exp_latency(op) - 1);
        e.err  = (op == 2'b11);
        e.lat  = exp_latency(op);
        sb.push_back(e);
        step();
        req_valid = 1'b0;
        c         = 1;
        got       = 1'b0;
        n_checks++;
        if (nl_mode !== op || nl_in !== data) begin
            n_fail++;
            $display("[TB] FAIL %s latch: mode %0d in %h expected mode %0d in %h",
                     name, nl_mode, nl_in, op, data);
        end
        while (!got && c < 400) begin
            n_checks++;
            if (ctrl_obs !== exp_ctrl(op, c)) begin
                n_fail++;
                $display("[TB] FAIL %s ctrl cycle %0d: got %b expected %b",
                         name, c, ctrl_obs, exp_ctrl(op, c));
            end
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                e   = sb.pop_front();
                n_checks++;
                if (c != e.lat) begin
                    n_fail++;
                    $display("[TB] FAIL %s latency: got %0d expected %0d", name, c, e.lat);
                end
                n_checks++;
                if (rsp_data !== e.data || rsp_err !== e.err) begin
                    n_fail++;
                    $display("[TB] FAIL %s response: data %h err %b expected data %h err %b",
                             name, rsp_data, rsp_err, e.data, e.err);
                end
            end else begin
                if (c == 10) begin
                    req_valid = 1'b1;
                    req_op    = 2'b11;
                    req_data  = ~data;
                end
                step();
                req_valid = 1'b0;
                c++;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s timeout: no rsp_valid after %0d cycles expected %0d",
                     name, c, exp_latency(op));
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            req_valid = (i % 2 == 0);
            req_op    = 2'b00;
            req_data  = ~data;
            step();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== held || req_ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL %s hold %0d: valid %b data %h ready %b expected 1 %h 0",
                         name, i, rsp_valid, rsp_data, req_ready, held);
            end
        end
        req_valid = 1'b0;
        n_checks++;
        if (nl_mode !== op || nl_in !== data) begin
            n_fail++;
            $display("[TB] FAIL %s busy_ignore: mode %0d in %h expected mode %0d in %h",
                     name, nl_mode, nl_in, op, data);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s handshake: valid %b ready %b expected 0 1",
                     name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = '0;
        rsp_ready = 1'b0;
        step();
        step();
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== '0 ||
            ctrl_obs !== '0 || nl_mode !== '0 || nl_in !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: ready %b valid %b err %b data %h ctrl %b mode %0d in %h expected 1 0 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_data, ctrl_obs, nl_mode, nl_in);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset_abort();
        bit seen;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_data  = 64'h0100_0100_0100_0100;
        step();
        req_valid = 1'b0;
        for (int c = 1; c < 20; c++) step();
        n_checks++;
        if (ctrl_obs !== exp_ctrl(2'b00, 20)) begin
            n_fail++;
            $display("[TB] FAIL abort_pre: ctrl %b expected %b", ctrl_obs, exp_ctrl(2'b00, 20));
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (nl_en_mult !== 1'b0 || nl_en_add !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL abort_async: en_mult %b en_add %b valid %b ready %b expected 0 0 0 1",
                     nl_en_mult, nl_en_add, rsp_valid, req_ready);
        end
        step();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (rsp_valid === 1'b1 || ctrl_obs !== '0) seen = 1'b1;
            step();
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("[TB] FAIL abort_quiet: got activity after abort expected none");
        end
    endtask

    task automatic test_softmax();
        run_op(2'b00, 64'h0100_0100_0100_0100, 0, "softmax");
    endtask

    task automatic test_gelu();
        run_op(2'b01, 64'h0200_0200_0200_0200, 0, "gelu");
    endtask

    task automatic test_root();
        run_op(2'b10, 64'h0400_0900_1000_1900, 0, "root");
    endtask

    task automatic test_illegal();
        run_op(2'b11, 64'hDEAD_BEEF_0123_4567, 0, "illegal");
    endtask

    task automatic test_hold();
        bit seen;
        run_op(2'b00, 64'h0080_0100_0180_0200, 10, "hold");
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid === 1'b1 || ctrl_obs !== '0 || req_ready !== 1'b1) seen = 1'b1;
            step();
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("[TB] FAIL hold_no_accept: got activity after handshake expected idle");
        end
    endtask

    task automatic test_back_to_back();
        run_op(2'b01, 64'h0011_0022_0033_0044, 0, "b2b_gelu");
        run_op(2'b10, 64'h0100_0400_0900_1000, 0, "b2b_root");
        run_op(2'b11, 64'h1234_5678_9ABC_DEF0, 3, "b2b_illegal");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_reset_abort();
        test_softmax();
        test_gelu();
        test_root();
        test_illegal();
        test_hold();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
